// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: 1-cycle registered grant held for the whole CYC,
// a mandatory idle cycle between grants, and a watchdog that ends stalled transfers with ERR.
module wb_bus_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_i,
  input  logic                 ack_i,
  input  logic                 err_i,
  input  logic                 rty_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [ID_WIDTH-1:0]  gnt_id_o,
  output logic                 bus_busy_o,
  output logic [N_MASTERS-1:0] force_err_o,
  output logic                 timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit                 WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = WD_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [ID_WIDTH-1:0]  LAST_RST = ID_WIDTH'(N_MASTERS - 1);

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    last_q, last_d;
  logic [N_MASTERS-1:0]   block_q, block_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]    gnt_id_q, gnt_id_d;
  logic [N_MASTERS-1:0]   force_err_q, force_err_d;
  logic                   timeout_q, timeout_d;

  logic [N_MASTERS-1:0]   masked;
  logic                   found;
  logic [ID_WIDTH-1:0]    win_id;
  logic                   term;

  function automatic logic [ID_WIDTH-1:0] rr_idx(input logic [ID_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_MASTERS) s = s - N_MASTERS;
    return ID_WIDTH'(s);
  endfunction

  assign masked = req_i & ~block_q;
  assign term   = ack_i | err_i | rty_i;

  // Scan from farthest to nearest so the nearest set bit after last_q wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      if (masked[rr_idx(last_q, k)]) begin
        found  = 1'b1;
        win_id = rr_idx(last_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    block_d     = block_q & req_i;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    force_err_d = '0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          last_d   = win_id;
          gnt_d    = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_id;
          gnt_id_d = win_id;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        // Owner release wins over a termination or a timeout in the same cycle.
        if (!req_i[gnt_id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (term) begin
          cnt_d = '0;
        end else if (WD_EN && (cnt_q == TO_LAST)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          timeout_d   = 1'b1;
          force_err_d = gnt_q;
          block_d     = block_d | gnt_q;
        end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      block_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      force_err_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      block_q     <= block_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      force_err_q <= force_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign bus_busy_o  = |gnt_q;
  assign force_err_o = force_err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with an 8-cycle watchdog.
module tb_wb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic       ack_i, err_i, rty_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       bus_busy_o;
  logic [3:0] force_err_o;
  logic       timeout_o;

  int tests;
  int fails;

  wb_bus_arbiter #(
    .N_MASTERS(4), .ID_WIDTH(2), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
    .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .bus_busy_o(bus_busy_o),
    .force_err_o(force_err_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b0;
    req_i = 4'b0000;
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    req_i = 4'b0000;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    tick();
    tests++;
    if (gnt_o !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
    tests++;
    if (gnt_id_o !== 2'd0) begin fails++; $display("FAIL reset_id got=%0d exp=0", gnt_id_o); end
    tests++;
    if (bus_busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus_busy_o); end
    tests++;
    if (force_err_o !== 4'b0000 || timeout_o !== 1'b0) begin
      fails++; $display("FAIL reset_wd got force=%b to=%b exp 0000/0", force_err_o, timeout_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req_i = 4'b0001;
    tick();
    tests++;
    if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0 || bus_busy_o !== 1'b1) begin
      fails++; $display("FAIL single_grant got gnt=%b id=%0d busy=%b exp 0001/0/1", gnt_o, gnt_id_o, bus_busy_o);
    end
    for (int c = 1; c <= 5; c++) begin
      ack_i = (c == 3);
      tick();
      tests++;
      if (gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin
        fails++; $display("FAIL single_hold c=%0d got gnt=%b to=%b exp 0001/0", c, gnt_o, timeout_o);
      end
    end
    ack_i = 1'b0;
    req_i = 4'b0000;
    tick();
    tests++;
    if (gnt_o !== 4'b0000 || bus_busy_o !== 1'b0 || timeout_o !== 1'b0) begin
      fails++; $display("FAIL single_release got gnt=%b busy=%b to=%b exp 0000/0/0", gnt_o, bus_busy_o, timeout_o);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    apply_reset();
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << order[g];
      tick();
      tests++;
      if (gnt_o !== exp || gnt_id_o !== 2'(order[g])) begin
        fails++; $display("FAIL rr_grant%0d got gnt=%b id=%0d exp %b/%0d", g, gnt_o, gnt_id_o, exp, order[g]);
      end
      tick();
      tests++;
      if (gnt_o !== exp) begin fails++; $display("FAIL rr_hold%0d got=%b exp=%b", g, gnt_o, exp); end
      req_i = 4'b1111 & ~exp;
      tick();
      tests++;
      if (gnt_o !== 4'b0000) begin fails++; $display("FAIL rr_idle%0d got=%b exp=0000", g, gnt_o); end
      req_i = 4'b1111;
    end
    req_i = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_priority_wrap();
    apply_reset();
    req_i = 4'b0100;
    tick();
    req_i = 4'b0000;
    tick();
    req_i = 4'b1011;
    tick();
    tests++;
    if (gnt_o !== 4'b1000 || gnt_id_o !== 2'd3) begin
      fails++; $display("FAIL wrap_m3 got gnt=%b id=%0d exp 1000/3", gnt_o, gnt_id_o);
    end
    req_i = 4'b0011;
    tick();
    tests++;
    if (gnt_o !== 4'b0000) begin fails++; $display("FAIL wrap_idle got=%b exp=0000", gnt_o); end
    tick();
    tests++;
    if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0) begin
      fails++; $display("FAIL wrap_m0 got gnt=%b id=%0d exp 0001/0", gnt_o, gnt_id_o);
    end
    req_i = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    apply_reset();
    req_i = 4'b0010;
    tick();
    tests++;
    if (gnt_o !== 4'b0010) begin fails++; $display("FAIL wd_grant got=%b exp=0010", gnt_o); end
    req_i = 4'b0110;
    for (int c = 1; c <= 7; c++) begin
      tick();
      tests++;
      if (gnt_o !== 4'b0010 || timeout_o !== 1'b0 || force_err_o !== 4'b0000) begin
        fails++; $display("FAIL wd_wait c=%0d got gnt=%b to=%b fe=%b exp 0010/0/0000", c, gnt_o, timeout_o, force_err_o);
      end
    end
    tick();
    tests++;
    if (timeout_o !== 1'b1 || force_err_o !== 4'b0010 || gnt_o !== 4'b0000) begin
      fails++; $display("FAIL wd_fire got to=%b fe=%b gnt=%b exp 1/0010/0000", timeout_o, force_err_o, gnt_o);
    end
    tick();
    tests++;
    if (timeout_o !== 1'b0 || force_err_o !== 4'b0000) begin
      fails++; $display("FAIL wd_pulse got to=%b fe=%b exp 0/0000", timeout_o, force_err_o);
    end
    tests++;
    if (gnt_o !== 4'b0100 || gnt_id_o !== 2'd2) begin
      fails++; $display("FAIL wd_other got gnt=%b id=%0d exp 0100/2", gnt_o, gnt_id_o);
    end
    req_i = 4'b0010;
    tick();
    tick();
    tick();
    tests++;
    if (gnt_o !== 4'b0000) begin fails++; $display("FAIL wd_blocked got=%b exp=0000", gnt_o); end
    req_i = 4'b0000;
    tick();
    req_i = 4'b0010;
    tick();
    tests++;
    if (gnt_o !== 4'b0010) begin fails++; $display("FAIL wd_unblock got=%b exp=0010", gnt_o); end
    req_i = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_ack_release();
    apply_reset();
    req_i = 4'b0001;
    tick();
    for (int c = 1; c <= 7; c++) tick();
    ack_i = 1'b1;
    req_i = 4'b0000;
    tick();
    ack_i = 1'b0;
    tests++;
    if (gnt_o !== 4'b0000 || timeout_o !== 1'b0 || force_err_o !== 4'b0000) begin
      fails++; $display("FAIL ackrel got gnt=%b to=%b fe=%b exp 0000/0/0000", gnt_o, timeout_o, force_err_o);
    end
    // An ack on the last cycle alone restarts the count instead of firing.
    req_i = 4'b0001;
    tick();
    tick();
    for (int c = 1; c <= 6; c++) tick();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    tests++;
    if (gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin
      fails++; $display("FAIL ack_restart got gnt=%b to=%b exp 0001/0", gnt_o, timeout_o);
    end
    req_i = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_i = 4'b0100;
    tick();
    tests++;
    if (gnt_o !== 4'b0100) begin fails++; $display("FAIL ar_pre got=%b exp=0100", gnt_o); end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (gnt_o !== 4'b0000 || bus_busy_o !== 1'b0 || gnt_id_o !== 2'd0 ||
        force_err_o !== 4'b0000 || timeout_o !== 1'b0) begin
      fails++; $display("FAIL ar_clear got gnt=%b busy=%b id=%0d fe=%b to=%b exp all 0",
                        gnt_o, bus_busy_o, gnt_id_o, force_err_o, timeout_o);
    end
    req_i = 4'b1100;
    #2;
    rst = 1'b1;
    tick();
    tests++;
    if (gnt_o !== 4'b0100 || gnt_id_o !== 2'd2 || force_err_o !== 4'b0000) begin
      fails++; $display("FAIL ar_rearb got gnt=%b id=%0d fe=%b exp 0100/2/0000", gnt_o, gnt_id_o, force_err_o);
    end
    req_i = 4'b0000;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    req_i = 4'b0000;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority_wrap();
    test_watchdog();
    test_ack_release();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Round-robin Wishbone bus arbiter that shares the node-side Wishbone bus between up to N_MASTERS masters (the NIC master port, the node CPU, DMA). It produces the one-hot grant vector, including the NIC's `gnt_wb_i`, holds a grant for the whole CYC cycle, and enforces a watchdog that terminates stalled transfers with a forced error.

## Interface
Parameters:
- N_MASTERS, 4, number of requesting masters (2..8)
- ID_WIDTH, 2, width of the encoded grant index, equal to ceil(log2(N_MASTERS))
- TIMEOUT_CYCLES, 64, cycles without a slave termination before the watchdog fires; 0 disables it
- CNT_WIDTH, 8, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous, active-low reset
- req_i, in, N_MASTERS, per-master CYC
- ack_i, in, 1, ACK from the currently selected slave
- err_i, in, 1, ERR from the currently selected slave
- rty_i, in, 1, RTY from the currently selected slave
- gnt_o, out, N_MASTERS, one-hot grant, registered
- gnt_id_o, out, ID_WIDTH, index of the granted master; valid while bus_busy_o is high
- bus_busy_o, out, 1, high while any gnt_o bit is set
- force_err_o, out, N_MASTERS, one-cycle ERR pulse to the master whose transfer timed out
- timeout_o, out, 1, one-cycle pulse when the watchdog fires

## Operation
- States:
  - IDLE: no grant. Arbitrate over `req_i & ~block`.
  - GRANT: exactly one gnt_o bit set.
- IDLE → GRANT when the masked request is nonzero.
  - Winner is the first set bit searching upward, with wrap, from `last+1`.
  - On entry, load `last` with the winner and set gnt_o and gnt_id_o.
- GRANT → IDLE when req_i[owner] = 0. gnt_o clears at that edge.
- Minimum one IDLE cycle between grants. No back-to-back regrant, even to a different master.
- Reset: state IDLE, `last` = N_MASTERS-1 (master 0 has highest priority first), block = 0, counter = 0.
  - gnt_o = 0, gnt_id_o = 0, bus_busy_o = 0, force_err_o = 0, timeout_o = 0.
- Watchdog (active only when TIMEOUT_CYCLES ≠ 0):
  - In GRANT, the counter clears on any cycle where ack_i | err_i | rty_i is high. Otherwise it increments.
  - When the counter equals TIMEOUT_CYCLES-1 and the current cycle has no termination, at the next edge:
    - timeout_o = 1 and force_err_o[owner] = 1, both for one cycle.
    - gnt_o clears, state → IDLE, block[owner] set.
  - The counter clears on every entry to GRANT. It saturates and never wraps.
- block[i] clears when req_i[i] = 0 is sampled. A timed-out master must drop CYC before it can be granted again.
- Terminations and the owner's request drop in the same cycle: the release takes precedence and no timeout occurs.
- Requests from non-owners during GRANT are ignored. They are held and arbitrated in the next IDLE cycle.
- Reset asserted mid-transfer clears all outputs asynchronously. No forced error is generated.

## Timing
- Grant latency: req_i[i] rises before edge n while IDLE → gnt_o[i] = 1 after edge n (1 cycle).
- Release: req_i[owner] low before edge n → gnt_o = 0 after edge n. The earliest next grant appears after edge n+1.
- Watchdog: grant at edge g with no terminations → timeout_o and force_err_o high for exactly the cycle after edge g+TIMEOUT_CYCLES.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single request: reset, then req_i=0001 held 5 cycles with ack_i pulsed on cycle 3 → gnt_o=0001 one cycle after req, gnt_id_o=0; drop req → gnt_o=0000 next cycle; no timeout_o.
- Round-robin fairness: req_i=1111 held, each owner drops and reraises CYC after 2 cycles → grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Priority wrap: last=2, then req_i=1011 → master 3 granted; after release with req_i=0011 → master 0 granted.
- Watchdog: TIMEOUT_CYCLES=8, req_i=0010, no ack → timeout_o and force_err_o=0010 pulse 8 cycles after grant, gnt_o=0000. Master 1 keeps req high plus master 2 requests → master 2 granted, master 1 never regranted until it drops req for one cycle.
- Simultaneous ack and release on the timeout cycle → clean release, timeout_o stays 0.
- Async reset mid-grant: rst low between edges while gnt_o=0100 → all outputs 0 immediately. After release of reset with req_i=0100 → grant is re-arbitrated from master 0 priority.
